// File: rtl/regfile_mp.sv
// regfile_mp: 2-read/2-write register file, r0 hardwired to zero, per-register busy scoreboard
// and a post-reset clear sequencer; define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wen0,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              wen1,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              bset,
   input  logic [ADDR_W-1:0] bset_addr,
   output logic              busy1,
   output logic              busy2,
   output logic              ready
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [0:0] INIT = 1'b0;
   localparam logic [0:0] RUN = 1'b1;
   logic [0:0] state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0] busy, set_v, clr_v;
   logic run;
   assign run = state == RUN;
   assign ready = run;
   // bit 0 of both masks is forced low so r0 never becomes busy
   always_comb begin
      set_v = '0;
      clr_v = '0;
      if (bset) set_v[bset_addr] = 1'b1;
      if (wen0) clr_v[waddr0] = 1'b1;
      if (wen1) clr_v[waddr1] = 1'b1;
      set_v[0] = 1'b0;
      clr_v[0] = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt <= '0;
         busy <= '0;
      end else if (!run) begin
         mem[cnt] <= '0;
         cnt <= cnt + 1'b1;
         if (cnt == ADDR_W'(DEPTH - 1)) state <= RUN;
      end else begin
         busy <= set_v | (busy & ~clr_v);
         if (wen0 && waddr0 != '0) mem[waddr0] <= wdata0;
         if (wen1 && waddr1 != '0) mem[waddr1] <= wdata1;
      end
   end
   function automatic logic [DATA_W-1:0] rd_f(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
      return (!run || a == '0) ? '0 :
             (wen1 && waddr1 == a) ? wdata1 :
             (wen0 && waddr0 == a) ? wdata0 : mem[a];
`else
      return (!run || a == '0) ? '0 : mem[a];
`endif
   endfunction
   // a clear this cycle is forwarded only when no new producer claims the register
   function automatic logic bz_f(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
      return run && busy[a] && !(clr_v[a] && !set_v[a]);
`else
      return run && busy[a];
`endif
   endfunction
   assign rdata1 = rd_f(raddr1);
   assign rdata2 = rd_f(raddr2);
   assign busy1 = bz_f(raddr1);
   assign busy2 = bz_f(raddr2);
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp; stimulus pushes expected outputs from an
// array-based reference model, a negedge monitor pops and compares.
module tb_regfile_mp;
   logic clk = 0, rst = 1;
   logic wen0 = 0, wen1 = 0, bset = 0;
   logic [4:0] waddr0 = 0, waddr1 = 0, raddr1 = 0, raddr2 = 0, bset_addr = 0;
   logic [31:0] wdata0 = 0, wdata1 = 0;
   logic [31:0] rdata1, rdata2;
   logic busy1, busy2, ready;

   regfile_mp dut (
      .clk(clk), .rst(rst),
      .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
      .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
      .bset(bset), .bset_addr(bset_addr), .busy1(busy1), .busy2(busy2), .ready(ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic b1;
      logic b2;
      logic rdy;
   } exp_t;
   exp_t q[$];
   logic [31:0] mdl [32];
   bit mbusy [32];
   int left = 32;
   int checks = 0, passed = 0;

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (left != 0 || a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
      if (wen1 && waddr1 == a) return wdata1;
      if (wen0 && waddr0 == a) return wdata0;
`endif
      return mdl[a];
   endfunction

   function automatic logic exp_bz(input logic [4:0] a);
      if (left != 0 || a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
      if (((wen0 && waddr0 == a) || (wen1 && waddr1 == a)) && !(bset && bset_addr == a)) return 0;
`endif
      return mbusy[a];
   endfunction

   // push what the outputs must show this cycle, then advance the model across the edge
   task automatic step();
      exp_t e;
      e.d1 = exp_rd(raddr1);
      e.d2 = exp_rd(raddr2);
      e.b1 = exp_bz(raddr1);
      e.b2 = exp_bz(raddr2);
      e.rdy = (left == 0);
      q.push_back(e);
      @(posedge clk);
      if (rst) begin
         left = 32;
         foreach (mbusy[i]) mbusy[i] = 0;
      end else if (left > 0) begin
         left--;
         if (left == 0) foreach (mdl[i]) mdl[i] = 0;
      end else begin
         if (wen0 && waddr0 != 0) begin mdl[waddr0] = wdata0; mbusy[waddr0] = 0; end
         if (wen1 && waddr1 != 0) begin mdl[waddr1] = wdata1; mbusy[waddr1] = 0; end
         if (bset && bset_addr != 0) mbusy[bset_addr] = 1;
      end
      #1;
   endtask

   task automatic idle();
      wen0 = 0;
      wen1 = 0;
      bset = 0;
   endtask

   function automatic logic [4:0] rnd_addr();
      return $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
   endfunction

   task automatic rnd_in(input bit keep_r1);
      wen0 = 1'($urandom_range(0, 1));
      wen1 = 1'($urandom_range(0, 1));
      bset = 1'($urandom_range(0, 1));
      waddr0 = rnd_addr();
      waddr1 = rnd_addr();
      bset_addr = rnd_addr();
      wdata0 = $urandom;
      wdata1 = $urandom;
      if (!keep_r1) raddr1 = rnd_addr();
      raddr2 = rnd_addr();
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rdata1", rdata1, e.d1);
            chk("rdata2", rdata2, e.d2);
            chk("busy1", 32'(busy1), 32'(e.b1));
            chk("busy2", 32'(busy2), 32'(e.b2));
            chk("ready", 32'(ready), 32'(e.rdy));
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      rst = 0;
      raddr1 = 5;
      repeat (33) step();
      wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
      step();
      idle();
      step();
      rst = 1;
      step();
      rst = 0;
      for (int i = 0; i < 33; i++) begin
         if (i > 8) rnd_in(1); else idle();
         step();
      end
      idle();
      step();
      raddr1 = 0; wen0 = 1; waddr0 = 0; wdata0 = 32'h12345678;
      step();
      idle();
      step();
      wen0 = 1; wen1 = 1; waddr0 = 7; waddr1 = 7; wdata0 = 32'hAAAA0000; wdata1 = 32'h5555FFFF;
      step();
      idle();
      raddr2 = 7;
      step();
      wen0 = 1; wen1 = 1; waddr0 = 3; waddr1 = 4; wdata0 = 32'h33333333; wdata1 = 32'h44444444;
      step();
      idle();
      raddr1 = 3; raddr2 = 4;
      step();
      bset = 1; bset_addr = 9;
      step();
      idle();
      raddr1 = 9;
      step();
      wen1 = 1; waddr1 = 9; wdata1 = 32'h99; bset = 1; bset_addr = 9;
      step();
      idle();
      step();
      wen1 = 1; waddr1 = 9; wdata1 = 32'h999;
      step();
      idle();
      step();
      raddr1 = 12; wen0 = 1; waddr0 = 12; wdata0 = 32'hCAFEF00D;
      step();
      idle();
      step();
      rst = 1;
      step();
      rst = 0;
      repeat (10) step();
      rst = 1;
      step();
      rst = 0;
      for (int i = 0; i < 33; i++) begin
         rnd_in(0);
         step();
      end
      for (int i = 0; i < 400; i++) begin
         rnd_in(0);
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 0;
      for (int i = 0; i < 40; i++) begin
         rnd_in(0);
         step();
      end
      idle();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (q.size() == 0) passed++;
      else $display("FAIL queue: %0d entries left, expected 0", q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
